// File: rtl/lectura_rtc.sv
// lectura_rtc: read-side controller for the RTC address/data bus.
// Reads one register through the shared bus controller using the activa/fin
// handshake. Clock (0x21-0x26) and timer (0x41-0x43) registers are preceded by
// a "transfer to buffer" command write. The captured byte is then held on
// dato_leido while final_out stays high until iniciar drops.
//
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   iniciar         : level request, held high for the whole transaction
//   dir             : register address to read (sampled in INICIO)
//   fin, data_in    : bus controller completion pulse and returned byte
//   data_out        : byte presented to the bus controller (command byte only)
//   dir_out         : address presented to the bus controller
//   escribe, activa : access direction (1 = write) and access request
//   dato_leido      : captured read byte
//   final_out       : transaction done (the name "final" is a reserved word)
//   error           : timeout flag
//
// Optional feature: define LECTURA_TIMEOUT_EN to abort a bus access that sees
// no fin within TIMEOUT_CYC cycles. Without it, error is constant 0.
module lectura_rtc #(
    parameter logic [7:0]  CMD_CLK     = 8'hF1,
    parameter logic [7:0]  CMD_TMR     = 8'hF3
`ifdef LECTURA_TIMEOUT_EN
    ,
    parameter logic [15:0] TIMEOUT_CYC = 16'd1000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [7:0] dir,
    input  logic       fin,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic [7:0] dir_out,
    output logic       escribe,
    output logic       activa,
    output logic [7:0] dato_leido,
    output logic       final_out,
    output logic       error
);

    typedef enum logic [2:0] {
        INICIO    = 3'd0,
        CMD       = 3'd1,
        GAP       = 3'd2,
        LEER      = 3'd3,
        FINALIZAR = 3'd4
    } state_t;

    state_t     state;
    logic       time_reg_c;
    logic       timer_reg_c;
    logic [7:0] cmd_byte_c;
    logic       timeout_c;

    // Address classification for the buffer-transfer command
    assign timer_reg_c = (dir >= 8'h41) && (dir <= 8'h43);
    assign time_reg_c  = ((dir >= 8'h21) && (dir <= 8'h26)) || timer_reg_c;
    assign cmd_byte_c  = timer_reg_c ? CMD_TMR : CMD_CLK;

`ifdef LECTURA_TIMEOUT_EN
    logic [15:0] cnt;

    // Cycles spent in the current bus access; zero outside CMD/LEER so it
    // starts from 0 on every entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 16'd0;
        end else if ((state == CMD || state == LEER) && iniciar && !fin) begin
            cnt <= cnt + 16'd1;
        end else begin
            cnt <= 16'd0;
        end
    end

    assign timeout_c = (state == CMD || state == LEER) && !fin &&
                       (cnt == TIMEOUT_CYC - 16'd1);
`else
    assign timeout_c = 1'b0;
`endif

    // Sequencer; outputs are loaded with the values of the state being entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= INICIO;
            data_out   <= 8'h00;
            dir_out    <= 8'h00;
            escribe    <= 1'b0;
            activa     <= 1'b0;
            dato_leido <= 8'h00;
            final_out  <= 1'b0;
            error      <= 1'b0;
        end else if (state != INICIO && !iniciar) begin
            // Abort: everything idles except the last captured byte
            state     <= INICIO;
            data_out  <= 8'h00;
            dir_out   <= 8'h00;
            escribe   <= 1'b0;
            activa    <= 1'b0;
            final_out <= 1'b0;
            error     <= 1'b0;
        end else if (timeout_c) begin
            state     <= FINALIZAR;
            data_out  <= 8'h00;
            dir_out   <= 8'h00;
            escribe   <= 1'b0;
            activa    <= 1'b0;
            final_out <= 1'b1;
            error     <= 1'b1;
        end else begin
            case (state)
                INICIO: begin
                    final_out <= 1'b0;
                    error     <= 1'b0;
                    if (iniciar && time_reg_c) begin
                        state    <= CMD;
                        dir_out  <= cmd_byte_c;
                        data_out <= cmd_byte_c;
                        escribe  <= 1'b1;
                        activa   <= 1'b1;
                    end else if (iniciar) begin
                        state    <= LEER;
                        dir_out  <= dir;
                        data_out <= 8'h00;
                        escribe  <= 1'b0;
                        activa   <= 1'b1;
                    end
                end
                CMD: begin
                    if (fin) begin
                        state    <= GAP;
                        dir_out  <= 8'h00;
                        data_out <= 8'h00;
                        escribe  <= 1'b0;
                        activa   <= 1'b0;
                    end
                end
                GAP: begin
                    state    <= LEER;
                    dir_out  <= dir;
                    data_out <= 8'h00;
                    escribe  <= 1'b0;
                    activa   <= 1'b1;
                end
                LEER: begin
                    if (fin) begin
                        state      <= FINALIZAR;
                        dato_leido <= data_in;
                        dir_out    <= 8'h00;
                        activa     <= 1'b0;
                        final_out  <= 1'b1;
                    end
                end
                FINALIZAR: begin
                    state <= FINALIZAR;
                end
                default: begin
                    state     <= INICIO;
                    data_out  <= 8'h00;
                    dir_out   <= 8'h00;
                    escribe   <= 1'b0;
                    activa    <= 1'b0;
                    final_out <= 1'b0;
                    error     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/lectura_rtc.md
Name: lectura_rtc

Overview:
- Read-side controller for the RTC address/data bus; the read-direction counterpart of the bus write sequencer.
- On `iniciar`, it reads one register through the low-level bus controller using the `activa`/`fin` handshake. For clock/timer registers, it first issues a "transfer to buffer" command.
- It then captures the returned byte and signals `final` until `iniciar` drops.
- Sits between the top-level register-access FSM and the shared bus controller.

Parameters:
- `CMD_CLK`, 8'hF1, command byte written (as both address and data) before reading a clock register (0x21–0x26).
- `CMD_TMR`, 8'hF3, command byte written (as both address and data) before reading a timer register (0x41–0x43).
- `TIMEOUT_CYC`, 16'd1000, cycles to wait for `fin` per bus access (used only with `LECTURA_TIMEOUT_EN`).

Ports:
- `clk`, input, 1, system clock; all state changes on the rising edge.
- `reset`, input, 1, asynchronous, active-high; clears state and all outputs.
- `iniciar`, input, 1, level request; must stay high for the whole transaction.
- `dir`, input, 8, register address to read; must be stable while `iniciar` is high.
- `fin`, input, 1, one-cycle pulse from the bus controller when the current access completes.
- `data_in`, input, 8, byte returned by the bus controller; valid in the cycle `fin` is high during a read access.
- `data_out`, output, 8, data byte presented to the bus controller (command byte only).
- `dir_out`, output, 8, address presented to the bus controller.
- `escribe`, output, 1, 1 = write access, 0 = read access; meaningful only while `activa` = 1.
- `activa`, output, 1, requests a bus access; held high until `fin`.
- `dato_leido`, output, 8, captured read byte.
- `final`, output, 1, transaction done; high while in FINALIZAR.
- `error`, output, 1, timeout flag; tied 0 without `LECTURA_TIMEOUT_EN`.

Behaviour:
- Reset: asynchronous and active-high; the clock is `clk` and the reset port is `reset`.
  - All outputs go to 0 (`data_out`, `dir_out`, `dato_leido` = 8'h00).
  - State = INICIO.
- Clocking: all outputs are registered and updated on the same edge that enters a state. Each output reflects the state just entered, with no extra lag.
- `iniciar` = 0 in any state other than INICIO: synchronous abort on the next edge.
  - Go to INICIO and clear all outputs except `dato_leido`, which holds.
- Time register: `dir` in {0x21..0x26, 0x41..0x43}. Command byte = `CMD_TMR` if `dir` is 0x41..0x43, otherwise `CMD_CLK`.
- States:
  - INICIO: `activa` = `escribe` = `final` = 0. If `iniciar` = 1, go to CMD if `dir` is a time register, otherwise go to LEER.
  - CMD: `dir_out` = `data_out` = command byte, `escribe` = 1, `activa` = 1. On `fin`, go to GAP.
  - GAP: exactly one cycle with `activa` = 0 and `data_out` = 0; then go to LEER. Guarantees the bus controller sees `activa` fall between accesses.
  - LEER: `dir_out` = `dir`, `data_out` = 0, `escribe` = 0, `activa` = 1. On `fin`, latch `dato_leido` <= `data_in` on that edge, then go to FINALIZAR.
  - FINALIZAR: `activa` = 0, `dir_out` = 0, `final` = 1. Stay while `iniciar` = 1; go to INICIO when `iniciar` = 0.
  - Illegal encoding: go to INICIO.
- `dato_leido` changes only in LEER on `fin`, or on reset. It is valid whenever `final` = 1.
- `fin` outside CMD/LEER is ignored.
- `fin` in the same cycle `iniciar` falls: the abort wins and no capture occurs.
- Back-to-back transactions: `iniciar` must go low at least one cycle. A new `dir` is sampled only in INICIO.

Optional Feature:
- Macro: `LECTURA_TIMEOUT_EN`.
- When defined:
  - A 16-bit counter clears on entry to CMD and LEER and increments each cycle `activa` = 1 without `fin`.
  - At `TIMEOUT_CYC`, go to FINALIZAR with `error` = 1 and `final` = 1; `dato_leido` is unchanged.
  - `error` clears in INICIO.
- When undefined: no counter; the FSM waits for `fin` indefinitely and `error` is constant 0.

Test Plan:
1. `dir` = 0x10, `iniciar` = 1, `fin` pulse with `data_in` = 0x5A → one read access (`escribe` = 0, `dir_out` = 0x10); `dato_leido` = 0x5A; `final` = 1; no CMD phase.
2. `dir` = 0x23 → first access is a write with `dir_out` = `data_out` = 0xF1; then one idle GAP cycle; then a read at 0x23 capturing `data_in` = 0x47; `final` = 1.
3. `dir` = 0x42 → command 0xF3, then read at 0x42; `data_in` = 0x09 gives `dato_leido` = 0x09.
4. Drop `iniciar` mid-LEER before `fin` → next edge in INICIO, `activa` = 0, `dato_leido` keeps its prior value; a later `fin` has no effect.
5. Assert `reset` asynchronously during CMD → outputs go to 0 immediately, without waiting for an edge; the FSM restarts in INICIO after release.
6. With `LECTURA_TIMEOUT_EN` and `TIMEOUT_CYC` = 20, no `fin` in LEER → after 20 cycles `final` = 1, `error` = 1, `activa` = 0; dropping `iniciar` clears `error`.
